// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// 32 shift-add or restoring-divide steps, then a sign-fix cycle.
module muldiv_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [1:0]  op_q;
    logic [63:0] acc_q;
    logic [31:0] b_q;
    logic [31:0] a_raw_q;
    logic        sgn_q;
    logic        dsgn_q;
    logic        bzero_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        in_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        op_div;
    logic        op_signed;
    logic [32:0] mul_sum;
    logic [32:0] div_r;
    logic [33:0] div_diff;
    logic [63:0] acc_d;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        in_signed = ~op[0];
        a_abs     = (in_signed && A[31]) ? (~A + 32'd1) : A;
        b_abs     = (in_signed && B[31]) ? (~B + 32'd1) : B;
        op_div    = op_q[1];
        op_signed = ~op_q[0];
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        div_r     = {acc_q[63:32], acc_q[31]};
        div_diff  = {1'b0, div_r} - {2'b00, b_q};
        acc_d     = acc_q;
        if (op_div) begin
            // Remainder stays below the divisor, so 32 bits always hold it.
            if (!div_diff[33])
                acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
            else
                acc_d = {div_r[31:0], acc_q[30:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[31:1]};
        end
        prod_fix = (op_signed && sgn_q) ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = (op_signed && sgn_q) ? (~acc_q[31:0] + 32'd1)
                                        : acc_q[31:0];
        rem_fix  = (op_signed && dsgn_q) ? (~acc_q[63:32] + 32'd1)
                                         : acc_q[63:32];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 2'd0;
            acc_q   <= 64'd0;
            b_q     <= 32'd0;
            a_raw_q <= 32'd0;
            sgn_q   <= 1'b0;
            dsgn_q  <= 1'b0;
            bzero_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        acc_q   <= {32'd0, a_abs};
                        b_q     <= b_abs;
                        a_raw_q <= A;
                        sgn_q   <= A[31] ^ B[31];
                        dsgn_q  <= A[31];
                        bzero_q <= (B == 32'd0);
                        cnt_q   <= 6'd0;
                        dz_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        if (hi_we)
                            hi_q <= wdata;
                        if (lo_we)
                            lo_q <= wdata;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31)
                        state_q <= FIX;
                end
                FIX: begin
                    if (op_div && bzero_q) begin
                        lo_q <= 32'hFFFF_FFFF;
                        hi_q <= a_raw_q;
                        dz_q <= 1'b1;
                    end else if (op_div) begin
                        lo_q <= quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        lo_q <= prod_fix[31:0];
                        hi_q <= prod_fix[63:32];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    always #5 clock = ~clock;

    muldiv_unit dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issue one op and wait for done; checks latency and HI/LO stability.
    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] h0;
        logic [31:0] l0;
        int          cyc;
        bit          held;
        h0    = hi;
        l0    = lo;
        held  = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        chk({tag, "_dz_clr"}, {31'd0, div_zero}, 32'd0);
        while (!done && cyc < 100) begin
            if (!busy || hi !== h0 || lo !== l0)
                held = 1'b0;
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd33);
        chk({tag, "_held"}, {31'd0, held}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        tick();
        chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        A       = 32'd0;
        B       = 32'd0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = 32'd0;
        repeat (2) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset_n = 1'b1;
        tick();

        do_op("multu", MULTU, 32'h0000_0001, 32'hF000_0005,
              32'h0000_0000, 32'hF000_0005);
        do_op("mult", MULT, 32'h0000_0001, 32'hF000_0005,
              32'hFFFF_FFFF, 32'hF000_0005);
        do_op("mult_nn", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h0000_0001);
        do_op("multu_big", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001);
        do_op("divu", DIVU, 32'hF000_0005, 32'h0000_0010,
              32'h0000_0005, 32'h0F00_0000);
        do_op("div_neg", DIV, 32'hFFFF_FFF9, 32'h0000_0002,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000);
        do_op("div0", DIV, 32'h0000_0007, 32'h0000_0000,
              32'h0000_0007, 32'hFFFF_FFFF);
        chk("div0_flag", {31'd0, div_zero}, 32'd1);
        do_op("after_div0", MULTU, 32'h0000_0002, 32'h0000_0004,
              32'h0000_0000, 32'h0000_0008);
        chk("dz_stays_clr", {31'd0, div_zero}, 32'd0);

        // Start and MTHI while busy must both be ignored.
        op    = MULTU;
        A     = 32'd2;
        B     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        op    = DIVU;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        cyc   = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("busy_ign_lat", 32'(cyc), 32'd27);
        chk("busy_ign_hi", hi, 32'd0);
        chk("busy_ign_lo", lo, 32'd6);
        tick();
        chk("no_queue", {31'd0, busy}, 32'd0);

        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        tick();
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_hi", hi, 32'd0);
        chk("mtlo_done", {31'd0, done}, 32'd0);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h55AA_55AA;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mtboth_hi", hi, 32'h55AA_55AA);
        chk("mtboth_lo", lo, 32'h55AA_55AA);

        // Start beats MTLO in the same cycle.
        op    = MULTU;
        A     = 32'd7;
        B     = 32'd9;
        start = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0BAD_0BAD;
        tick();
        start = 1'b0;
        lo_we = 1'b0;
        chk("start_wins_busy", {31'd0, busy}, 32'd1);
        chk("start_wins_lo", lo, 32'h55AA_55AA);
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("start_wins_res", lo, 32'd63);
        tick();

        // Asynchronous reset in the middle of a divide.
        op    = DIVU;
        A     = 32'd1000;
        B     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        do_op("post_rst", MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit for the MIPS datapath, sitting beside the combinational ALU and owning the HI/LO register pair. It accepts an operation request with operands, iterates for a fixed 32 steps (shift-add multiply or restoring divide), applies sign correction, and writes HI/LO. Pipeline control stalls on `busy` and reads results through `hi`/`lo`.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `A`  in  32  multiplicand / dividend.
- `B`  in  32  multiplier / divisor.
- `hi_we`  in  1  MTHI strobe; writes `wdata` to HI when idle.
- `lo_we`  in  1  MTLO strobe; writes `wdata` to LO when idle.
- `wdata`  in  32  data for MTHI/MTLO.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `div_zero`  out  1  last DIV/DIVU had B==0; holds until the next accepted start.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `start`: capture `op`. Capture |A| and |B| for signed ops, raw values otherwise. Record the result sign (A[31]^B[31]) and the dividend sign (A[31]). Clear `count` and `div_zero`, then go to CALC.
- CALC: perform one iteration per cycle on a 6-bit counter. After the iteration with count==31, go to FIX.
- Multiply: 64-bit shift-add over 32 multiplier bits.
- Divide: restoring, 1 quotient bit per cycle, 33-bit trial subtract.
- FIX, multiply: negate the 64-bit product if signed and signs differ. HI = product[63:32], LO = product[31:0].
- FIX, divide: negate the quotient if signed and signs differ. Negate the remainder if signed and the dividend was negative. LO = quotient, HI = remainder.
- FIX always: pulse `done` and return to IDLE.
- Divide by zero (B==0): LO=32'hFFFFFFFF, HI=A (unmodified dividend), `div_zero`=1. Full latency is still spent; no sign fix is applied.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `start` while busy is ignored; no queueing.
- `hi_we`/`lo_we` while busy are ignored.
- In IDLE, `start` and `hi_we`/`lo_we` in the same cycle: `start` wins and the writes are dropped.
- `hi_we` and `lo_we` together in IDLE: both registers are written with `wdata`.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, counter=0.
- `start` sampled at edge N. `busy`=1 from after edge N through edge N+33, and 0 after edge N+33.
- `hi`/`lo` update at edge N+33. `done`=1 for exactly the cycle between edges N+33 and N+34.
- Total latency is 33 edges from acceptance to result. Back-to-back: the next `start` is accepted at edge N+34 at the earliest.
- MTHI/MTLO in IDLE: register updates at the sampling edge, with no `done` pulse.
- `hi`/`lo` hold their old values throughout CALC; no intermediate values are visible.
- Reset mid-operation aborts immediately, leaving no partial HI/LO update, and clears all outputs.

## Test plan
- MULTU A=0x00000001, B=0xF0000005 -> after 33 edges HI=0x00000000, LO=0xF0000005, one-cycle `done`, `busy` high for 33 cycles.
- MULT A=0x00000001, B=0xF0000005 -> HI=0xFFFFFFFF, LO=0xF0000005. Then MULT 0xFFFFFFFF × 0xFFFFFFFF -> HI=0, LO=1.
- DIVU 0xF0000005 / 0x00000010 -> LO=0x0F000000, HI=0x00000005. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x00000007 / 0 -> LO=0xFFFFFFFF, HI=0x00000007, `div_zero`=1. The next MULTU start clears `div_zero`.
- During busy, pulse `start` with new operands and `hi_we` with 0xDEADBEEF -> both ignored; the original result lands unchanged. In IDLE, `lo_we`=1, `wdata`=0x12345678 -> `lo`=0x12345678 next cycle, `done` stays 0.
- Assert `reset_n`=0 at cycle 15 of a DIVU -> `busy`, `done`, `hi`, `lo` go to 0 immediately. After release, a new MULTU 3×5 gives LO=15, HI=0.
